// File: rtl/reverb_param_bank.sv
// ---------------------------------------------------------------------------
// reverb_param_bank
//
// This module holds a bank of reverb parameters. Each parameter can be changed
// in two ways:
//   * Front-panel buttons. These drive `update`. The module detects edges on
//     that input. Repeated presses in the same direction on the same
//     parameter make the step size larger.
//   * Direct writes from the HPS. These use load_en, load_idx and load_val.
//
// Ports
//   clk_clk        : clock. All logic runs on its rising edge.
//   reset_reset_n  : asynchronous reset, active low.
//   param_sel      : index of the parameter that update acts on (async source).
//   update[1:0]    : bit0 = increment, bit1 = decrement (async level inputs).
//   load_en        : one-cycle direct-write strobe.
//   load_idx       : target index for load_en.
//   load_val       : value to write. It is clipped to MAX_VAL.
//   param_vals     : all values. Parameter i is at bits [i*VAL_W +: VAL_W].
//   chg_valid      : one-cycle pulse when a parameter value is written.
//   chg_idx        : index of that parameter. Valid while chg_valid is high.
//
// Request timing
//   A rising edge on update that is first sampled at clock edge k appears on
//   param_vals after edge k+3:
//     k, k+1 : two-flop synchroniser
//     k+2    : request register (_p0)
//     k+3    : parameter write
// ---------------------------------------------------------------------------
module reverb_param_bank #(
    parameter int              NUM_PARAMS   = 4,
    parameter int              SEL_W        = 4,
    parameter int              VAL_W        = 24,
    parameter logic [VAL_W-1:0] STEP        = 24'h010000,
    parameter logic [VAL_W-1:0] MAX_VAL     = 24'hFFFFFF,
    parameter logic [VAL_W-1:0] RESET_VAL   = 24'h400000,
    parameter int              ACCEL_WINDOW = 1000
) (
    input  logic                        clk_clk,
    input  logic                        reset_reset_n,
    input  logic [SEL_W-1:0]            param_sel,
    input  logic [1:0]                  update,
    input  logic                        load_en,
    input  logic [SEL_W-1:0]            load_idx,
    input  logic [VAL_W-1:0]            load_val,
    output logic [NUM_PARAMS*VAL_W-1:0] param_vals,
    output logic                        chg_valid,
    output logic [SEL_W-1:0]            chg_idx
);

    localparam int               WIN_W    = $clog2(ACCEL_WINDOW + 1);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(ACCEL_WINDOW - 1);
    localparam logic [SEL_W:0]   SEL_LIM  = (SEL_W + 1)'(NUM_PARAMS);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    // -----------------------------------------------------------------------
    // Saturation and step helpers
    // -----------------------------------------------------------------------
    function automatic logic [VAL_W-1:0] sat_inc(input logic [VAL_W-1:0] v,
                                                 input logic [VAL_W:0]   s);
        logic [VAL_W:0] sum;
        sum = {1'b0, v} + s;
        if (sum > {1'b0, MAX_VAL})
            return MAX_VAL;
        return sum[VAL_W-1:0];
    endfunction

    // The extra top bit works as a borrow flag. When it is set the result
    // went below zero, so the function returns zero.
    function automatic logic [VAL_W-1:0] sat_dec(input logic [VAL_W-1:0] v,
                                                 input logic [VAL_W:0]   s);
        logic [VAL_W:0] diff;
        diff = {1'b0, v} - s;
        if (diff[VAL_W])
            return '0;
        return diff[VAL_W-1:0];
    endfunction

    function automatic logic [VAL_W-1:0] clip_load(input logic [VAL_W-1:0] v);
        return (v > MAX_VAL) ? MAX_VAL : v;
    endfunction

    // cnt is the burst position of the current request, where 1 is the first
    // press. Presses 1-3 use STEP, presses 4-7 use 4*STEP, and later presses
    // use 16*STEP.
    function automatic logic [VAL_W:0] step_for(input logic [3:0] cnt);
        if (cnt <= 4'd3)
            return {1'b0, STEP};
        if (cnt <= 4'd7)
            return {1'b0, STEP} << 2;
        return {1'b0, STEP} << 4;
    endfunction

    // -----------------------------------------------------------------------
    // Synchroniser stages (s1, s2) and the edge-detect register (s3)
    // -----------------------------------------------------------------------
    logic [1:0]       upd_s1, upd_s2, upd_s3;
    logic [SEL_W-1:0] sel_s1, sel_s2;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            upd_s1 <= '0;
            upd_s2 <= '0;
            upd_s3 <= '0;
            sel_s1 <= '0;
            sel_s2 <= '0;
        end else begin
            upd_s1 <= update;
            upd_s2 <= upd_s1;
            upd_s3 <= upd_s2;
            sel_s1 <= param_sel;
            sel_s2 <= sel_s1;
        end
    end

    logic [1:0] upd_rise;
    logic       req_ok;

    // A request is accepted only if exactly one direction bit rose and the
    // index is inside the bank. If both bits rose together, the request is
    // ignored.
    always_comb begin
        upd_rise = upd_s2 & ~upd_s3;
        req_ok   = (upd_rise[0] ^ upd_rise[1]) && ({1'b0, sel_s2} < SEL_LIM);
    end

    // -----------------------------------------------------------------------
    // Stage p0: request register
    // -----------------------------------------------------------------------
    logic             req_vld_p0;
    logic             req_dir_p0;   // 1 = decrement
    logic [SEL_W-1:0] req_idx_p0;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            req_vld_p0 <= 1'b0;
            req_dir_p0 <= 1'b0;
            req_idx_p0 <= '0;
        end else begin
            req_vld_p0 <= req_ok;
            req_dir_p0 <= upd_rise[1];
            req_idx_p0 <= sel_s2;
        end
    end

    // -----------------------------------------------------------------------
    // Acceleration FSM
    // -----------------------------------------------------------------------
    state_t           state_q, state_nx;
    logic [3:0]       cnt_q, cnt_nx;
    logic [WIN_W-1:0] win_q, win_nx;
    logic             dir_q, dir_nx;
    logic [SEL_W-1:0] idx_q, idx_nx;

    logic load_hit;
    logic take_req;

    always_comb begin
        load_hit = load_en && ({1'b0, load_idx} < SEL_LIM);
        take_req = req_vld_p0 && !load_hit;
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            win_q   <= '0;
            dir_q   <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_nx;
            cnt_q   <= cnt_nx;
            win_q   <= win_nx;
            dir_q   <= dir_nx;
            idx_q   <= idx_nx;
        end
    end

    always_comb begin
        state_nx = state_q;
        cnt_nx   = cnt_q;
        win_nx   = win_q;
        dir_nx   = dir_q;
        idx_nx   = idx_q;

        if (req_vld_p0 && load_hit) begin
            // A load in the same cycle drops the request and ends any burst.
            state_nx = IDLE;
            cnt_nx   = '0;
            win_nx   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_vld_p0) begin
                        state_nx = BURST;
                        cnt_nx   = 4'd1;
                        win_nx   = '0;
                        dir_nx   = req_dir_p0;
                        idx_nx   = req_idx_p0;
                    end
                end
                BURST: begin
                    if (req_vld_p0) begin
                        win_nx = '0;
                        if (req_dir_p0 == dir_q && req_idx_p0 == idx_q) begin
                            if (cnt_q != 4'd15)
                                cnt_nx = cnt_q + 4'd1;
                        end else begin
                            cnt_nx = 4'd1;
                            dir_nx = req_dir_p0;
                            idx_nx = req_idx_p0;
                        end
                    end else if (win_q >= WIN_LAST) begin
                        state_nx = IDLE;
                        cnt_nx   = '0;
                        win_nx   = '0;
                    end else begin
                        win_nx = win_q + 1'b1;
                    end
                end
                default: begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                    win_nx   = '0;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Stage p1: parameter write
    // -----------------------------------------------------------------------
    logic [VAL_W-1:0] vals_q [NUM_PARAMS];
    logic [VAL_W-1:0] cur_val;
    logic [VAL_W-1:0] new_val;

    always_comb begin
        cur_val = '0;
        for (int i = 0; i < NUM_PARAMS; i++) begin
            if (req_idx_p0 == SEL_W'(i))
                cur_val = vals_q[i];
        end
        new_val = req_dir_p0 ? sat_dec(cur_val, step_for(cnt_nx))
                             : sat_inc(cur_val, step_for(cnt_nx));
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            for (int i = 0; i < NUM_PARAMS; i++)
                vals_q[i] <= RESET_VAL;
            chg_valid <= 1'b0;
            chg_idx   <= '0;
        end else begin
            chg_valid <= 1'b0;
            if (load_hit) begin
                for (int i = 0; i < NUM_PARAMS; i++) begin
                    if (load_idx == SEL_W'(i))
                        vals_q[i] <= clip_load(load_val);
                end
                chg_valid <= 1'b1;
                chg_idx   <= load_idx;
            end else if (take_req && (new_val != cur_val)) begin
                for (int i = 0; i < NUM_PARAMS; i++) begin
                    if (req_idx_p0 == SEL_W'(i))
                        vals_q[i] <= new_val;
                end
                chg_valid <= 1'b1;
                chg_idx   <= req_idx_p0;
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_PARAMS; g++) begin : g_pack
            assign param_vals[g*VAL_W +: VAL_W] = vals_q[g];
        end
    endgenerate

endmodule

// File: tb/tb_reverb_param_bank.sv
// ---------------------------------------------------------------------------
// tb_reverb_param_bank
//
// Directed testbench for reverb_param_bank with the default parameters.
// The expected values below are worked out by hand.
//
// Burst step rule: the N-th press of a burst uses
//   STEP      for N = 1..3
//   4*STEP    for N = 4..7
//   16*STEP   for N >= 8
// ---------------------------------------------------------------------------
module tb_reverb_param_bank;

    logic        clk_clk = 1'b0;
    logic        reset_reset_n;
    logic [3:0]  param_sel;
    logic [1:0]  update;
    logic        load_en;
    logic [3:0]  load_idx;
    logic [23:0] load_val;
    logic [95:0] param_vals;
    logic        chg_valid;
    logic [3:0]  chg_idx;

    int tests = 0;
    int fails = 0;
    int chg_cnt = 0;
    int base;

    reverb_param_bank dut (
        .clk_clk       (clk_clk),
        .reset_reset_n (reset_reset_n),
        .param_sel     (param_sel),
        .update        (update),
        .load_en       (load_en),
        .load_idx      (load_idx),
        .load_val      (load_val),
        .param_vals    (param_vals),
        .chg_valid     (chg_valid),
        .chg_idx       (chg_idx)
    );

    always #5 clk_clk = ~clk_clk;

    // Count change pulses, sampled on the falling edge.
    always @(negedge clk_clk) begin
        if (chg_valid === 1'b1)
            chg_cnt++;
    end

    function automatic logic [23:0] val(input int i);
        return param_vals[i*24 +: 24];
    endfunction

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk_clk);
    endtask

    // Hold the update bits high for two clock edges, then release them.
    task automatic pulse(input logic [1:0] b);
        @(negedge clk_clk) update = b;
        @(negedge clk_clk);
        @(negedge clk_clk) update = 2'b00;
    endtask

    task automatic set_sel(input logic [3:0] s);
        @(negedge clk_clk) param_sel = s;
        wait_cyc(4);
    endtask

    task automatic do_load(input logic [3:0] idx, input logic [23:0] v);
        @(negedge clk_clk);
        load_en  = 1'b1;
        load_idx = idx;
        load_val = v;
        @(negedge clk_clk) load_en = 1'b0;
    endtask

    logic [23:0] exp_v;

    initial begin
        reset_reset_n = 1'b0;
        param_sel     = '0;
        update        = '0;
        load_en       = 1'b0;
        load_idx      = '0;
        load_val      = '0;

        // Reset state
        wait_cyc(3);
        chk("rst_vals", param_vals, {4{24'h400000}});
        chk("rst_chg_valid", chg_valid, 1'b0);
        chk("rst_chg_idx", chg_idx, 4'd0);
        @(negedge clk_clk) reset_reset_n = 1'b1;
        wait_cyc(10);
        chk("idle_vals", param_vals, {4{24'h400000}});
        chk("idle_no_chg", chg_cnt, 0);

        // Single increment on index 2 and its latency
        set_sel(4'd2);
        base = chg_cnt;
        @(negedge clk_clk) update = 2'b01;
        repeat (3) @(posedge clk_clk);
        #1;
        chk("lat_k2_val", val(2), 24'h400000);
        chk("lat_k2_chg", chg_valid, 1'b0);
        @(posedge clk_clk);
        #1;
        chk("lat_k3_val", val(2), 24'h410000);
        chk("lat_k3_chg", chg_valid, 1'b1);
        chk("lat_k3_idx", chg_idx, 4'd2);
        wait_cyc(20);
        chk("held_level_val", val(2), 24'h410000);
        chk("held_level_pulses", chg_cnt - base, 1);
        @(negedge clk_clk) update = 2'b00;
        wait_cyc(5);

        // Ten presses on index 1, 100 cycles apart
        set_sel(4'd1);
        base  = chg_cnt;
        exp_v = 24'h400000;
        for (int n = 1; n <= 10; n++) begin
            pulse(2'b01);
            wait_cyc(98);
            exp_v = exp_v + ((n <= 3) ? 24'h010000 : (n <= 7) ? 24'h040000 : 24'h100000);
            chk($sformatf("accel_step%0d", n), val(1), exp_v);
        end
        chk("accel_final", val(1), 24'h830000);
        chk("accel_pulses", chg_cnt - base, 10);

        // After the window expires, the next press is a new burst
        wait_cyc(1100);
        pulse(2'b01);
        wait_cyc(10);
        chk("window_expire", val(1), 24'h840000);

        // Load, then increment into saturation
        base = chg_cnt;
        @(negedge clk_clk);
        load_en  = 1'b1;
        load_idx = 4'd0;
        load_val = 24'hFFF000;
        @(posedge clk_clk);
        #1;
        chk("load_val", val(0), 24'hFFF000);
        chk("load_chg", chg_valid, 1'b1);
        chk("load_idx", chg_idx, 4'd0);
        @(negedge clk_clk) load_en = 1'b0;
        set_sel(4'd0);
        pulse(2'b01);
        wait_cyc(10);
        chk("sat_max", val(0), 24'hFFFFFF);
        base = chg_cnt;
        pulse(2'b01);
        wait_cyc(10);
        chk("sat_max_hold", val(0), 24'hFFFFFF);
        chk("sat_max_no_chg", chg_cnt - base, 0);

        // Decrement, then decrement into saturation at zero
        set_sel(4'd3);
        pulse(2'b10);
        wait_cyc(10);
        chk("dec_val", val(3), 24'h3F0000);
        do_load(4'd3, 24'h008000);
        pulse(2'b10);
        wait_cyc(10);
        chk("sat_zero", val(3), 24'h000000);

        // A load to an index outside the bank is ignored
        base = chg_cnt;
        do_load(4'd5, 24'h123456);
        wait_cyc(5);
        chk("load_oob_vals", param_vals, {24'h000000, 24'h410000, 24'h840000, 24'hFFFFFF});
        chk("load_oob_no_chg", chg_cnt - base, 0);

        // Both bits rising together, and an out-of-range selector
        set_sel(4'd2);
        base = chg_cnt;
        pulse(2'b11);
        wait_cyc(10);
        chk("both_bits_val", val(2), 24'h410000);
        set_sel(4'd7);
        pulse(2'b01);
        wait_cyc(10);
        chk("sel7_vals", param_vals, {24'h000000, 24'h410000, 24'h840000, 24'hFFFFFF});
        chk("ignored_no_chg", chg_cnt - base, 0);

        // Load collides with a request on index 3.
        // First build a burst of four presses on index 3:
        //   0 + 3*0x010000 + 0x040000 = 0x070000
        set_sel(4'd3);
        for (int n = 0; n < 4; n++) begin
            pulse(2'b01);
            wait_cyc(48);
        end
        chk("pre_collide", val(3), 24'h070000);
        base = chg_cnt;
        @(negedge clk_clk) update = 2'b01;
        repeat (3) @(posedge clk_clk);
        @(negedge clk_clk);
        load_en  = 1'b1;
        load_idx = 4'd3;
        load_val = 24'h123456;
        @(posedge clk_clk);
        #1;
        chk("collide_val", val(3), 24'h123456);
        chk("collide_chg", chg_valid, 1'b1);
        @(negedge clk_clk);
        load_en = 1'b0;
        update  = 2'b00;
        wait_cyc(10);
        chk("collide_one_pulse", chg_cnt - base, 1);
        chk("collide_hold", val(3), 24'h123456);
        // The FSM returned to IDLE, so this press uses STEP and not 4*STEP.
        pulse(2'b01);
        wait_cyc(10);
        chk("collide_fsm_idle", val(3), 24'h133456);

        // Reset while a request is still in flight
        set_sel(4'd0);
        @(negedge clk_clk) update = 2'b10;
        @(negedge clk_clk);
        update        = 2'b00;
        reset_reset_n = 1'b0;
        wait_cyc(3);
        @(negedge clk_clk) reset_reset_n = 1'b1;
        base = chg_cnt;
        wait_cyc(20);
        chk("midrst_vals", param_vals, {4{24'h400000}});
        chk("midrst_no_chg", chg_cnt - base, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
